weight_instr_dispatcher: RTL and testbench

WEIGHT_INSTR_DISPATCHER -- requirements
Module: weight_instr_dispatcher

---
 rtl/tpu_pkg.sv | 23 ++
 rtl/weight_instr_fifo.sv | 55 +++++
 rtl/weight_instr_dispatcher.sv | 117 +++++++++++
 tb/tb_weight_instr_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: weight instruction layout, its reset value, and the dispatcher FSM encoding.
package tpu_pkg;

  localparam int WEIGHT_OP_W   = 8;
  localparam int WEIGHT_LEN_W  = 16;
  localparam int WEIGHT_ADDR_W = 40;

  typedef struct packed {
    logic [WEIGHT_OP_W-1:0]   opcode;       // bit 0 = signed weights
    logic [WEIGHT_LEN_W-1:0]  length;
    logic [WEIGHT_ADDR_W-1:0] weight_addr;
  } weight_instr_type;

  localparam weight_instr_type INIT_WEIGHT_INSTR = '{opcode: '0, length: '0, weight_addr: '0};

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_ISSUE,
    WD_GUARD,
    WD_WAIT_DONE
  } weight_dispatch_state_e;

endpackage

// File: rtl/weight_instr_fifo.sv
// Weight instruction queue: registered storage, head visible combinationally, zero-latency pop.
// Full/empty reflect current occupancy only; the caller must not push when full.
module weight_instr_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  weight_instr_type push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output weight_instr_type head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  weight_instr_type mem_q [DEPTH];
  weight_instr_type mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_WEIGHT_INSTR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/weight_instr_dispatcher.sv
// Queues weight instructions and issues them one chunk at a time (issue one cycle after enqueue edge);
// enqueue stalls when the FIFO is full. WEIGHT_DISPATCH_SPLIT_EN splits long instructions into MATRIX_WIDTH chunks.
module weight_instr_dispatcher
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  weight_instr_type in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output weight_instr_type instr,
  output logic             instr_enable,
  input  logic             busy,
  input  logic             resource_busy,
  output logic             zero_len_drop,
  output logic             idle
);

  localparam logic [WEIGHT_ADDR_W-1:0] MW_ADDR = WEIGHT_ADDR_W'(MATRIX_WIDTH);
`ifdef WEIGHT_DISPATCH_SPLIT_EN
  localparam logic [WEIGHT_LEN_W-1:0] MW_LEN = WEIGHT_LEN_W'(MATRIX_WIDTH);
`endif

  weight_dispatch_state_e   state_q, state_d;
  weight_instr_type         instr_q, instr_d;
  logic [WEIGHT_LEN_W-1:0]  rem_q, rem_d;
  logic [WEIGHT_ADDR_W-1:0] next_addr_q, next_addr_d;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  weight_instr_type         fifo_head, src;
  logic [WEIGHT_LEN_W-1:0]  chunk_len;
  logic                     have_work;

  weight_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_instr),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rem_d         = rem_q;
    next_addr_d   = next_addr_q;
    fifo_pop      = 1'b0;
    zero_len_drop = 1'b0;
    instr_enable  = 1'b0;

    // A non-zero remainder means the head is mid-split; continue from the saved cursor.
    if (rem_q != '0) begin
      src = '{opcode: instr_q.opcode, length: rem_q, weight_addr: next_addr_q};
    end else begin
      src = fifo_head;
    end
`ifdef WEIGHT_DISPATCH_SPLIT_EN
    chunk_len = (src.length > MW_LEN) ? MW_LEN : src.length;
`else
    chunk_len = src.length;
`endif
    have_work = (rem_q != '0) || (!fifo_empty && (fifo_head.length != '0));

    unique case (state_q)
      WD_IDLE: begin
        if ((rem_q == '0) && !fifo_empty && (fifo_head.length == '0)) begin
          fifo_pop      = 1'b1;
          zero_len_drop = 1'b1;
        end else if (have_work && enable && !busy && !resource_busy) begin
          state_d     = WD_ISSUE;
          instr_d     = '{opcode: src.opcode, length: chunk_len, weight_addr: src.weight_addr};
          rem_d       = src.length - chunk_len;
          next_addr_d = src.weight_addr + MW_ADDR;
        end
      end
      WD_ISSUE: begin
        instr_enable = 1'b1;
        fifo_pop     = (rem_q == '0);
        state_d      = WD_GUARD;
      end
      // The controller raises busy one cycle late, so it is not trusted here.
      WD_GUARD: state_d = WD_WAIT_DONE;
      WD_WAIT_DONE: begin
        if (!busy) state_d = WD_IDLE;
      end
      default: state_d = WD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WD_IDLE;
      instr_q     <= INIT_WEIGHT_INSTR;
      rem_q       <= '0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rem_q       <= rem_d;
      next_addr_q <= next_addr_d;
    end
  end

  assign instr = instr_q;
  assign idle  = fifo_empty && (state_q == WD_IDLE);

endmodule

// File: tb/tb_weight_instr_dispatcher.sv
// Scoreboard bench for weight_instr_dispatcher with a simple busy-generating controller model.
module tb_weight_instr_dispatcher;
  import tpu_pkg::*;

  localparam int MW    = 14;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b1;
  logic             in_valid = 1'b0;
  logic             busy = 1'b0;
  logic             resource_busy = 1'b0;
  weight_instr_type in_instr = INIT_WEIGHT_INSTR;
  logic             in_ready, instr_enable, zero_len_drop, idle;
  weight_instr_type instr;

  int tests = 0, fails = 0;
  int pulses = 0, drops = 0, exp_pulses = 0, exp_drops = 0;
  int busy_cnt = 0;
  bit hold_busy = 1'b0;
  weight_instr_type expq[$];

  weight_instr_dispatcher #(.MATRIX_WIDTH(MW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_instr      (in_instr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .instr_enable  (instr_enable),
    .busy          (busy),
    .resource_busy (resource_busy),
    .zero_len_drop (zero_len_drop),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  function automatic weight_instr_type mk(input logic [7:0] op, input logic [15:0] len, input logic [39:0] addr);
    mk = '{opcode: op, length: len, weight_addr: addr};
  endfunction

  // Reference model: the chunks one instruction must produce.
  task automatic expect_instr(input weight_instr_type w);
`ifdef WEIGHT_DISPATCH_SPLIT_EN
    logic [15:0] rem, c;
    logic [39:0] a;
`endif
    if (w.length == 16'd0) begin
      exp_drops++;
      return;
    end
`ifdef WEIGHT_DISPATCH_SPLIT_EN
    rem = w.length;
    a   = w.weight_addr;
    while (rem != 16'd0) begin
      c = (rem > 16'(MW)) ? 16'(MW) : rem;
      expq.push_back(mk(w.opcode, c, a));
      exp_pulses++;
      rem = rem - c;
      a   = a + 40'(MW);
    end
`else
    expq.push_back(w);
    exp_pulses++;
`endif
  endtask

  // Controller model and output monitor.
  initial begin : monitor
    weight_instr_type e;
    forever begin
      @(negedge clk);
      if (rst && instr_enable) begin
        pulses++;
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL issue_while_busy busy=%b want 0", busy);
        end
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_issue got %h want none", instr);
        end else begin
          e = expq.pop_front();
          if (instr !== e) begin
            fails++;
            $display("FAIL chunk got %h want %h", instr, e);
          end
        end
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (rst && zero_len_drop) drops++;
      busy = hold_busy || (busy_cnt > 0);
    end
  end

  task automatic push(input weight_instr_type w);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL push_timeout in_ready=%b want 1", in_ready);
    end else begin
      in_instr = w;
      in_valid = 1'b1;
      expect_instr(w);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle && !busy && busy_cnt == 0) && n < 600);
    repeat (4) @(negedge clk);
    tests++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL %s_idle got %b want 1", tag, idle);
    end
    tests++;
    if (pulses != exp_pulses || expq.size() != 0) begin
      fails++;
      $display("FAIL %s_pulses got %0d want %0d (pending %0d)", tag, pulses, exp_pulses, expq.size());
    end
    tests++;
    if (drops != exp_drops) begin
      fails++;
      $display("FAIL %s_drops got %0d want %0d", tag, drops, exp_drops);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (instr !== INIT_WEIGHT_INSTR || instr_enable !== 1'b0 || zero_len_drop !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs instr=%h en=%b drop=%b want %h 0 0", instr, instr_enable, zero_len_drop, INIT_WEIGHT_INSTR);
    end
    tests++;
    if (in_ready !== 1'b1 || idle !== 1'b1) begin
      fails++;
      $display("FAIL reset_status in_ready=%b idle=%b want 1 1", in_ready, idle);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    weight_instr_type w = mk(8'h09, 16'd14, 40'h21);
    @(negedge clk);
    in_instr = w;
    in_valid = 1'b1;
    expect_instr(w);
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (instr_enable !== 1'b0) begin
      fails++;
      $display("FAIL latency_early en=%b want 0", instr_enable);
    end
    @(negedge clk);
    tests++;
    if (instr_enable !== 1'b1) begin
      fails++;
      $display("FAIL latency_issue en=%b want 1", instr_enable);
    end
    wait_idle("single");
  endtask

  task automatic test_split();
    push(mk(8'h01, 16'd30, 40'h81));
    wait_idle("split");
    push(mk(8'h00, 16'd20, 40'hFF_FFFF_FFF8));
    wait_idle("split_wrap");
  endtask

  task automatic test_backpressure();
    int base;
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    base = pulses;
    for (int i = 0; i < DEPTH; i++) push(mk(8'h02, 16'd5, 40'h100 + 40'(i * 16)));
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full in_ready=%b want 0", in_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || pulses != base) begin
      fails++;
      $display("FAIL bp_hold in_ready=%b pulses=%0d want 0 %0d", in_ready, pulses, base);
    end
    hold_busy = 1'b0;
    push(mk(8'h03, 16'd6, 40'h200));
    tests++;
    if (pulses < base + 1) begin
      fails++;
      $display("FAIL bp_fifth_before_pop pulses=%0d want >=%0d", pulses, base + 1);
    end
    wait_idle("backpressure");
  endtask

  task automatic test_zero_len();
    push(mk(8'h04, 16'd0, 40'h300));
    push(mk(8'h05, 16'd7, 40'h310));
    wait_idle("zero_len");
  endtask

  task automatic test_gating();
    int n;
    int base;
    for (int g = 0; g < 2; g++) begin
      if (g == 0) resource_busy = 1'b1; else enable = 1'b0;
      base = pulses;
      push(mk(8'h06, 16'd3, 40'h400 + 40'(g)));
      repeat (6) @(negedge clk);
      tests++;
      if (pulses != base || instr_enable !== 1'b0) begin
        fails++;
        $display("FAIL gate%0d_blocked pulses=%0d want %0d", g, pulses, base);
      end
      resource_busy = 1'b0;
      enable = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!instr_enable && n < 10);
      tests++;
      if (n < 1 || n > 2) begin
        fails++;
        $display("FAIL gate%0d_release cycles=%0d want 1..2", g, n);
      end
      wait_idle("gating");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) push(mk(8'h07, 16'd4, 40'h500 + 40'(i * 8)));
    hold_busy = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_enable && n < 20);
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (instr !== INIT_WEIGHT_INSTR || instr_enable !== 1'b0 || zero_len_drop !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outputs instr=%h en=%b drop=%b want %h 0 0", instr, instr_enable, zero_len_drop, INIT_WEIGHT_INSTR);
    end
    tests++;
    if (in_ready !== 1'b1 || idle !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_status in_ready=%b idle=%b want 1 1", in_ready, idle);
    end
    expq.delete();
    exp_pulses = pulses;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hold_busy = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (pulses != exp_pulses || idle !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_no_resume pulses=%0d idle=%b want %0d 1", pulses, idle, exp_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_backpressure();
    test_zero_len();
    test_gating();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
